// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, bus widths,
// reset PC default and the byte-lane insert helper used while assembling a word.
package inst_fetch_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;

  localparam logic [InstBus-1:0]     ZeroWord         = '0;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Little-endian: lane 0 is the byte at the lowest address.
  function automatic logic [InstBus-1:0] put_byte(input logic [InstBus-1:0] word,
                                                  input logic [1:0]         lane,
                                                  input logic [7:0]         data);
    logic [InstBus-1:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: byte memory port, IF/ID stall, branch redirect and
// the fetched instruction. master = fetch unit, slave = its environment.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                   mem_grant_i;
  logic                   mem_req_o;
  logic [InstAddrBus-1:0] mem_addr_o;
  logic [7:0]             mem_din_i;
  logic                   stall_i;
  logic                   branch_flag_i;
  logic [InstAddrBus-1:0] branch_target_i;
  logic [InstAddrBus-1:0] pc_o;
  logic [InstBus-1:0]     inst_o;
  logic                   inst_valid_o;

  modport master (
    input  mem_grant_i, mem_din_i, stall_i, branch_flag_i, branch_target_i,
    output mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o
  );

  modport slave (
    output mem_grant_i, mem_din_i, stall_i, branch_flag_i, branch_target_i,
    input  mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o
  );

endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup on
// the fetch PC, line written when a byte fetch completes.
module inst_icache
  import inst_fetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [InstAddrBus-1:2]   addr_i,
  output logic                     hit_o,
  output logic [InstBus-1:0]       word_o,
  input  logic                     fill_i,
  input  logic [InstBus-1:0]       fill_word_i
);

  localparam int IdxW = $clog2(LINES);
  localparam int TagW = InstAddrBus - 2 - IdxW;

  logic [TagW-1:0]    tag_mem  [LINES];
  logic [InstBus-1:0] data_mem [LINES];
  logic [LINES-1:0]   valid_q, valid_d;
  logic [IdxW-1:0]    idx;
  logic [TagW-1:0]    tag;

  assign idx    = addr_i[IdxW+1:2];
  assign tag    = addr_i[InstAddrBus-1:IdxW+2];
  assign hit_o  = valid_q[idx] && (tag_mem[idx] == tag);
  assign word_o = data_mem[idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_i) valid_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data arrays need no reset: the valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= fill_word_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 32-bit words from a byte-wide shared memory port.
// Optional I-cache compiled in with macro INST_FETCH_ICACHE_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int                     ICACHE_LINES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_fetch_if.master bus
);

  fetch_state_e           state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] pc_out_q, pc_out_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   mem_req;
  logic [InstAddrBus-1:0] mem_addr;
  logic                   cache_hit;
  logic [InstBus-1:0]     cache_word;
  logic                   active;

  assign active = rdy && !rst;

`ifdef INST_FETCH_ICACHE_EN
  logic fill_en;

  // A branch in the completing cycle aborts the fill.
  assign fill_en = active && (state_q == S_REQ) && (cnt_q == 3'd4) &&
                   bus.mem_grant_i && !bus.branch_flag_i;

  inst_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (pc_q[InstAddrBus-1:2]),
    .hit_o       (cache_hit),
    .word_o      (cache_word),
    .fill_i      (fill_en),
    .fill_word_i (inst_d)
  );
`else
  // Without the cache every lookup misses; the parameter stays part of the interface.
  assign cache_hit  = 1'b0 & (ICACHE_LINES > 0);
  assign cache_word = ZeroWord;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    mem_req      = 1'b0;
    mem_addr     = ZeroWord;
    if (active) begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if ((cnt_q == 3'd0) && cache_hit) begin
            state_d      = S_HOLD;
            inst_d       = cache_word;
            pc_out_d     = pc_q;
            inst_valid_d = 1'b1;
          end else begin
            mem_req = 1'b1;
            if (bus.mem_grant_i) begin
              if (cnt_q < 3'd4) mem_addr = pc_q + InstAddrBus'(cnt_q);
              // The byte on mem_din_i belongs to the address presented last cycle.
              if (cnt_q != 3'd0) inst_d = put_byte(inst_q, 2'(cnt_q - 3'd1), bus.mem_din_i);
              if (cnt_q == 3'd4) begin
                state_d      = S_HOLD;
                cnt_d        = 3'd0;
                pc_out_d     = pc_q;
                inst_valid_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 3'd1;
              end
            end else begin
              cnt_d = 3'd0;
            end
          end
        end
        S_HOLD: begin
          if (!bus.stall_i) begin
            pc_d         = pc_q + 32'd4;
            inst_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (bus.branch_flag_i) begin
        pc_d         = bus.branch_target_i;
        cnt_d        = 3'd0;
        inst_valid_d = 1'b0;
        state_d      = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      pc_q         <= RESET_PC;
      pc_out_q     <= ZeroWord;
      inst_q       <= ZeroWord;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.pc_o         = pc_out_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: byte memory responder, word/cache reference model and
// per-scenario tasks; covers both the default and INST_FETCH_ICACHE_EN builds.
`timescale 1ns/1ps
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LINES  = 64;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_err    = 0;
  int   n_checks = 0;
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  inst_fetch_if ifc ();

  inst_fetch #(.RESET_PC(RST_PC), .ICACHE_LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (ifc)
  );

  // Sparse byte memory, filled lazily with random contents.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_b(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {mem_b(a + 32'd3), mem_b(a + 32'd2), mem_b(a + 32'd1), mem_b(a)};
  endfunction

  // Read data returns one cycle after a granted address.
  always @(posedge clk) begin
    if (ifc.mem_req_o === 1'b1 && ifc.mem_grant_i === 1'b1)
      ifc.mem_din_i <= mem_b(ifc.mem_addr_o);
  end

`ifdef INST_FETCH_ICACHE_EN
  bit          c_valid [int];
  logic [29:0] c_tag   [int];
  logic [31:0] c_word  [int];

  function automatic int c_idx(input logic [31:0] a);
    return int'(a[31:2]) % LINES;
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] w);
    c_valid[c_idx(a)] = 1'b1;
    c_tag[c_idx(a)]   = a[31:2];
    c_word[c_idx(a)]  = w;
  endtask
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    ifc.stall_i = 1'b0;
    step();
    ifc.stall_i = 1'b1;
  endtask

  task automatic branch_to(input logic [31:0] t);
    ifc.branch_flag_i   = 1'b1;
    ifc.branch_target_i = t;
    step();
    ifc.branch_flag_i   = 1'b0;
  endtask

  // Called on the first S_REQ cycle of a fetch of pc with grant held high.
  task automatic run_fetch(input logic [31:0] pc, input string nm);
    logic [31:0] w;
    bit          hit;
    int          lat;
    int          c;
    hit = 1'b0;
    w   = model_word(pc);
`ifdef INST_FETCH_ICACHE_EN
    hit = c_valid.exists(c_idx(pc)) && (c_tag[c_idx(pc)] == pc[31:2]);
    if (hit) w = c_word[c_idx(pc)];
`endif
    lat = hit ? 1 : 5;
    c   = 0;
    while (ifc.inst_valid_o !== 1'b1 && c < 40) begin
      if (c == 0) begin
        n_checks++;
        if (ifc.mem_req_o !== !hit) begin
          n_err++; $display("FAIL %s mem_req_o: got %b want %b", nm, ifc.mem_req_o, !hit);
        end
      end
      if (!hit && c < 4) begin
        n_checks++;
        if (ifc.mem_addr_o !== pc + 32'(c)) begin
          n_err++; $display("FAIL %s addr[%0d]: got %h want %h", nm, c, ifc.mem_addr_o, pc + 32'(c));
        end
      end
      c++;
      step();
    end
    n_checks++;
    if (c != lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", nm, c, lat);
    end
    n_checks++;
    if (ifc.pc_o !== pc) begin
      n_err++; $display("FAIL %s pc_o: got %h want %h", nm, ifc.pc_o, pc);
    end
    n_checks++;
    if (ifc.inst_o !== w) begin
      n_err++; $display("FAIL %s inst_o: got %h want %h", nm, ifc.inst_o, w);
    end
    cur_pc = pc;
`ifdef INST_FETCH_ICACHE_EN
    if (!hit) model_fill(pc, w);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    ifc.branch_flag_i = 1'b1; ifc.branch_target_i = 32'h1234_5678;
    step();
    rdy = 1'b0;
    step();
    n_checks++;
    if (ifc.mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset mem_req_o: got %b want 0", ifc.mem_req_o); end
    n_checks++;
    if (ifc.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset mem_addr_o: got %h want 0", ifc.mem_addr_o); end
    n_checks++;
    if (ifc.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset inst_valid_o: got %b want 0", ifc.inst_valid_o); end
    n_checks++;
    if (ifc.pc_o !== 32'h0) begin n_err++; $display("FAIL reset pc_o: got %h want 0", ifc.pc_o); end
    n_checks++;
    if (ifc.inst_o !== 32'h0) begin n_err++; $display("FAIL reset inst_o: got %h want 0", ifc.inst_o); end
    ifc.branch_flag_i = 1'b0;
    rst = 1'b0; rdy = 1'b1;
    #1;
    n_checks++;
    if (ifc.mem_req_o !== 1'b0) begin n_err++; $display("FAIL idle mem_req_o: got %b want 0", ifc.mem_req_o); end
    step();
  endtask

  task automatic test_basic_fetch();
    run_fetch(RST_PC, "basic");
    n_checks++;
    if (ifc.inst_o !== 32'h0050_0013) begin
      n_err++; $display("FAIL basic word: got %h want 00500013", ifc.inst_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_pc, s_inst;
    int          n;
    s_pc = ifc.pc_o; s_inst = ifc.inst_o;
    n = 3 + int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if ({ifc.inst_valid_o, ifc.inst_o, ifc.pc_o, ifc.mem_req_o} !== {1'b1, s_inst, s_pc, 1'b0}) begin
        n_err++; $display("FAIL stall hold[%0d]: got v=%b %h @%h req=%b want v=1 %h @%h req=0",
                          i, ifc.inst_valid_o, ifc.inst_o, ifc.pc_o, ifc.mem_req_o, s_inst, s_pc);
      end
    end
    accept();
    run_fetch(s_pc + 32'd4, "after_stall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) step();
      accept();
      run_fetch(cur_pc + 32'd4, "b2b");
    end
  endtask

  task automatic test_branch();
    logic [31:0] t;
    int          at;
    for (int i = 0; i < 4; i++) begin
      at = (i == 0) ? 2 : int'($urandom_range(0, 4));
      t  = (i == 0) ? 32'h0000_1000 : (32'h4000_0000 | ($urandom & 32'h0FFF_FFFF));
      accept();
      repeat (at) step();
      branch_to(t);
      n_checks++;
      if (ifc.inst_valid_o !== 1'b0) begin
        n_err++; $display("FAIL branch@cnt%0d valid: got %b want 0", at, ifc.inst_valid_o);
      end
      run_fetch(t, "branch");
    end
    // Branch in S_HOLD together with an accept: the redirect wins over pc+4.
    t = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFC);
    ifc.stall_i = 1'b0;
    branch_to(t);
    ifc.stall_i = 1'b1;
    n_checks++;
    if (ifc.inst_valid_o !== 1'b0) begin
      n_err++; $display("FAIL branch_hold valid: got %b want 0", ifc.inst_valid_o);
    end
    run_fetch(t, "branch_hold");
  endtask

  task automatic test_grant_drop();
    int at;
    for (int i = 0; i < 2; i++) begin
      at = (i == 0) ? 3 : int'($urandom_range(1, 4));
      branch_to(32'h0000_9000 + 32'(i * 256));
      repeat (at) step();
      ifc.mem_grant_i = 1'b0;
      step();
      n_checks++;
      if (ifc.mem_req_o !== 1'b1) begin
        n_err++; $display("FAIL grant_drop req: got %b want 1", ifc.mem_req_o);
      end
      repeat ($urandom_range(0, 2)) step();
      ifc.mem_grant_i = 1'b1;
      #1;
      run_fetch(32'h0000_9000 + 32'(i * 256), "grant_drop");
    end
  endtask

  task automatic test_wrap();
    branch_to(32'hFFFF_FFFC);
    run_fetch(32'hFFFF_FFFC, "wrap_last");
    accept();
    run_fetch(32'h0000_0000, "wrap_zero");
    branch_to(32'hFFFF_FFFE);
    run_fetch(32'hFFFF_FFFE, "wrap_unaligned");
    accept();
    run_fetch(32'h0000_0002, "wrap_next");
  endtask

  task automatic test_rdy();
    logic [31:0] w;
    int          c;
    branch_to(32'h0000_8000);
    step(); step();
    rdy = 1'b0;
    ifc.branch_flag_i = 1'b1; ifc.branch_target_i = 32'hDEAD_0000;
    #1;
    n_checks++;
    if ({ifc.mem_req_o, ifc.mem_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rdy_low bus: got req=%b addr=%h want req=0 addr=0", ifc.mem_req_o, ifc.mem_addr_o);
    end
    repeat (3) begin
      step();
      n_checks++;
      if ({ifc.mem_req_o, ifc.inst_valid_o} !== 2'b00) begin
        n_err++; $display("FAIL rdy_freeze: got req=%b valid=%b want 0/0", ifc.mem_req_o, ifc.inst_valid_o);
      end
    end
    rdy = 1'b1; ifc.branch_flag_i = 1'b0;
    #1;
    n_checks++;
    if (ifc.mem_addr_o !== 32'h0000_8002) begin
      n_err++; $display("FAIL rdy_resume addr: got %h want 00008002", ifc.mem_addr_o);
    end
    c = 0;
    while (ifc.inst_valid_o !== 1'b1 && c < 40) begin c++; step(); end
    w = model_word(32'h0000_8000);
    n_checks++;
    if (c != 3) begin n_err++; $display("FAIL rdy_resume latency: got %0d want 3", c); end
    n_checks++;
    if ({ifc.pc_o, ifc.inst_o} !== {32'h0000_8000, w}) begin
      n_err++; $display("FAIL rdy_resume word: got %h @%h want %h @00008000", ifc.inst_o, ifc.pc_o, w);
    end
`ifdef INST_FETCH_ICACHE_EN
    model_fill(32'h0000_8000, w);
`endif
    // Freeze in S_HOLD: an accept offered while rdy is low must not be taken.
    rdy = 1'b0; ifc.stall_i = 1'b0;
    step(); step();
    n_checks++;
    if ({ifc.inst_valid_o, ifc.pc_o, ifc.mem_req_o} !== {1'b1, 32'h0000_8000, 1'b0}) begin
      n_err++; $display("FAIL rdy_hold: got v=%b pc=%h req=%b want v=1 pc=00008000 req=0",
                        ifc.inst_valid_o, ifc.pc_o, ifc.mem_req_o);
    end
    rdy = 1'b1;
    step();
    ifc.stall_i = 1'b1;
    run_fetch(32'h0000_8004, "rdy_after");
  endtask

  task automatic test_reset_mid();
    accept();
    step(); step();
    rst = 1'b1; rdy = 1'b0;
    ifc.branch_flag_i = 1'b1; ifc.branch_target_i = 32'h7777_0000;
    #1;
    n_checks++;
    if ({ifc.mem_req_o, ifc.mem_addr_o} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_mid bus: got req=%b addr=%h want req=0 addr=0", ifc.mem_req_o, ifc.mem_addr_o);
    end
    step();
    n_checks++;
    if ({ifc.inst_valid_o, ifc.pc_o, ifc.inst_o} !== {1'b0, 32'h0, 32'h0}) begin
      n_err++; $display("FAIL reset_mid regs: got v=%b pc=%h inst=%h want all 0",
                        ifc.inst_valid_o, ifc.pc_o, ifc.inst_o);
    end
    rst = 1'b0; rdy = 1'b1; ifc.branch_flag_i = 1'b0;
`ifdef INST_FETCH_ICACHE_EN
    c_valid.delete();
`endif
    step();
    run_fetch(RST_PC, "reset_mid_refetch");
  endtask

  task automatic test_loop_revisit();
    for (int i = 0; i < 3; i++) begin
      branch_to(32'h0000_0010);
      run_fetch(32'h0000_0010, "loop_head");
      accept();
      run_fetch(32'h0000_0014, "loop_body");
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    ifc.mem_grant_i = 1'b1; ifc.stall_i = 1'b1;
    ifc.branch_flag_i = 1'b0; ifc.branch_target_i = 32'h0;
    cur_pc = RST_PC;
    mem[32'h0] = 8'h13; mem[32'h1] = 8'h00; mem[32'h2] = 8'h50; mem[32'h3] = 8'h00;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_back_to_back();
    test_branch();
    test_grant_drop();
    test_wrap();
    test_rdy();
    test_reset_mid();
    test_loop_revisit();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter ICACHE_LINES, 64: direct-mapped I-cache entries, one 32-bit word each; power of 2 (used only with ICACHE_EN).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global ready; low freezes all state.
REQ-006 mem_grant_i  in  1  arbiter grants the byte memory port to fetch this cycle.
REQ-007 mem_req_o  out  1  fetch requests the memory port.
REQ-008 mem_addr_o  out  32  byte address presented this cycle.
REQ-009 mem_din_i  in  8  read byte, valid one cycle after its address.
REQ-010 stall_i  in  1  downstream (IF/ID) cannot accept this cycle.
REQ-011 branch_flag_i  in  1  redirect request from decode.
REQ-012 branch_target_i  in  32  redirect address.
REQ-013 pc_o  out  32  address of inst_o.
REQ-014 inst_o  out  32  assembled instruction word.
REQ-015 inst_valid_o  out  1  pc_o/inst_o hold a valid instruction.

Function
REQ-016 States: S_IDLE, S_REQ, S_HOLD; 3-bit byte counter cnt (0..4); registered pc.
REQ-017 S_IDLE: mem_req_o=0; next state S_REQ.
REQ-018 S_REQ: mem_req_o=1; if mem_grant_i and cnt<4, drive mem_addr_o=pc+cnt; if cnt>=1, capture mem_din_i into inst_o[8*(cnt-1)+:8] (little-endian); cnt increments each granted cycle.
REQ-019 When cnt reaches 4 with byte 3 captured: go to S_HOLD, cnt<=0, inst_valid_o<=1; miss latency = 5 granted cycles from entering S_REQ to inst_valid_o=1.
REQ-020 mem_grant_i low in S_REQ: cnt<=0, partial word discarded, fetch restarts at byte 0 on next grant.
REQ-021 S_HOLD: mem_req_o=0, pc_o/inst_o/inst_valid_o stable; if stall_i=0 the word is accepted that cycle: pc<=pc+4, inst_valid_o<=0, state S_REQ.
REQ-022 branch_flag_i=1 in any state: pc<=branch_target_i, cnt<=0, inst_valid_o<=0, state S_REQ; priority over accept, grant loss and stall_i.
REQ-023 Branch target used as given; no alignment check or exception.
REQ-024 pc+cnt and pc+4 wrap modulo 2^32.
REQ-025 rdy=0: no state, counter, pc or output register changes; mem_req_o=0.

Reset
REQ-026 rst=1 at clock edge: pc=RESET_PC, state S_IDLE, cnt=0, inst_o=0, pc_o=0, inst_valid_o=0; priority over rdy and branch.
REQ-027 Combinational outputs during reset: mem_req_o=0, mem_addr_o=0.
REQ-028 Reset mid-fetch discards the partial word; no memory request issued in the reset cycle.

Configuration
REQ-029 Macro INST_FETCH_ICACHE_EN: when defined, I-cache compiled in; index pc[log2(ICACHE_LINES)+1:2], tag remaining upper bits, one valid bit per line.
REQ-030 With cache: S_REQ with cnt=0 and tag hit -> mem_req_o=0, S_HOLD with the cached word next cycle (1-cycle latency); miss -> byte fetch per REQ-018, line filled on completion.
REQ-031 With cache: reset clears all valid bits; branch during fill aborts the fill, line unchanged.
REQ-032 Without macro: no cache storage, every fetch per REQ-018.

Structure
REQ-033 Shared package: state encoding, ZeroWord, InstBus/InstAddrBus widths, RESET_PC default.
REQ-034 Sub-module inst_icache (tag/data/valid arrays, lookup, fill) instantiated only under INST_FETCH_ICACHE_EN.

Verification
REQ-035 Reset, grant held, bytes 13,00,50,00 at 0..3 -> inst_o=32'h0050_0013, pc_o=0, inst_valid_o=1 five cycles after S_REQ.
REQ-036 S_HOLD with stall_i=1 for 3 cycles -> outputs stable; stall_i=0 -> next fetch addresses 4,5,6,7.
REQ-037 branch_flag_i=1, target 32'h0000_1000 at cnt=2 -> inst_valid_o=0, next addresses 1000..1003, pc_o=32'h1000.
REQ-038 Grant dropped at cnt=3 -> refetch restarts at pc+0; final word correct.
REQ-039 pc=32'hFFFF_FFFC accepted -> next fetch address 32'h0000_0000.
REQ-040 INST_FETCH_ICACHE_EN: loop branching back to 32'h10 -> second visit mem_req_o=0, inst_valid_o one cycle after S_REQ.
